pc_sequencer: RTL

//  Fetch/decode/execute control FSM driving the 8-bit program counter's enable/load controls.

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Sequencer-side bus: fetch handshake, decoder inputs and PC/regfile controls.
// master = pc_sequencer, slave = surrounding datapath / memory model.
interface pc_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              run;
    logic              stall;
    logic [ADDR_W-1:0] pc;
    logic              imem_req;
    logic              imem_ack;
    logic              ir_load;
    logic [2:0]        op_kind;
    logic              zero_flag;
    logic [ADDR_W-1:0] target;
    logic              exec_done;
    logic              pc_enable;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_addr;
    logic              reg_we;
    logic              halted;
    logic              fault;
    logic [2:0]        state;

    modport master (
        input  run, stall, pc, imem_ack, op_kind, zero_flag, target, exec_done,
        output imem_req, ir_load, pc_enable, pc_load, pc_load_addr, reg_we,
               halted, fault, state
    );

    modport slave (
        output run, stall, pc, imem_ack, op_kind, zero_flag, target, exec_done,
        input  imem_req, ir_load, pc_enable, pc_load, pc_load_addr, reg_we,
               halted, fault, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control FSM with hardware return-address stack.
// Define PC_SEQ_FETCH_TIMEOUT_EN to fault after FETCH_TIMEOUT unacknowledged fetch cycles.
module pc_sequencer #(
    parameter int ADDR_W        = 8,
    parameter int STACK_DEPTH   = 4,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU  = 3'd0,
        OP_JMP  = 3'd1,
        OP_JZ   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HALT = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_t;

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    state_t            state_q;
    op_t               op_q;
    logic              zero_q;
    logic [ADDR_W-1:0] target_q;
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_dec;
    logic [ADDR_W-1:0] stack_q [0:(1 << IDX_W)-1];
    logic              active;
    logic              push_ok;
    logic              pop_ok;
    logic              timeout;

    assign active  = !bus.stall;
    assign push_ok = (sp_q != SP_FULL);
    assign pop_ok  = (sp_q != '0);
    assign sp_dec  = sp_q - SP_W'(1);

`ifdef PC_SEQ_FETCH_TIMEOUT_EN
    localparam int TO_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt_q;
    assign timeout = (to_cnt_q == TO_LAST);
`else
    logic unused_fetch_timeout;
    assign timeout              = 1'b0;
    assign unused_fetch_timeout = (FETCH_TIMEOUT > 0);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ALU;
            zero_q   <= 1'b0;
            target_q <= '0;
            sp_q     <= '0;
            // NOTE: the stack is small and must read as cleared after reset,
            // so it lives in flops with reset rather than in a RAM macro.
            for (int i = 0; i < (1 << IDX_W); i++) stack_q[i] <= '0;
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else if (active) begin
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
            case (state_q)
                S_IDLE: if (bus.run) state_q <= S_FETCH;
                S_FETCH: begin
                    if (bus.imem_ack) state_q <= S_DECODE;
                    else if (timeout) state_q <= S_FAULT;
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
                    else to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
                end
                S_DECODE: begin
                    op_q     <= op_t'(bus.op_kind);
                    zero_q   <= bus.zero_flag;
                    target_q <= bus.target;
                    state_q  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (op_q)
                        OP_ALU:        if (bus.exec_done) state_q <= S_WB;
                        OP_JMP, OP_JZ: state_q <= S_FETCH;
                        OP_CALL: begin
                            // pc was already incremented in FETCH: it is the return address
                            if (push_ok) begin
                                stack_q[sp_q[IDX_W-1:0]] <= bus.pc;
                                sp_q    <= sp_q + SP_W'(1);
                                state_q <= S_FETCH;
                            end else begin
                                state_q <= S_FAULT;
                            end
                        end
                        OP_RET: begin
                            if (pop_ok) begin
                                sp_q    <= sp_dec;
                                state_q <= S_FETCH;
                            end else begin
                                state_q <= S_FAULT;
                            end
                        end
                        OP_HALT: state_q <= S_HALT;
                        default: state_q <= S_FAULT;
                    endcase
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  if (bus.run) state_q <= S_FETCH;
                default: state_q <= S_FAULT;
            endcase
        end
    end

    // Pulses answer same-cycle ack/exec/stall, so they decode the state register
    // combinationally; async reset to IDLE clears them immediately.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        bus.imem_req     = 1'b0;
        bus.ir_load      = 1'b0;
        bus.pc_enable    = 1'b0;
        bus.pc_load      = 1'b0;
        bus.pc_load_addr = '0;
        bus.reg_we       = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.imem_req = active;
                if (active && bus.imem_ack) begin
                    bus.ir_load   = 1'b1;
                    bus.pc_enable = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (active) begin
                    case (op_q)
                        OP_JMP: begin
                            bus.pc_load      = 1'b1;
                            bus.pc_load_addr = target_q;
                        end
                        OP_JZ: begin
                            if (zero_q) begin
                                bus.pc_load      = 1'b1;
                                bus.pc_load_addr = target_q;
                            end
                        end
                        OP_CALL: begin
                            if (push_ok) begin
                                bus.pc_load      = 1'b1;
                                bus.pc_load_addr = target_q;
                            end
                        end
                        OP_RET: begin
                            if (pop_ok) begin
                                bus.pc_load      = 1'b1;
                                bus.pc_load_addr = stack_q[sp_dec[IDX_W-1:0]];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_WB:    bus.reg_we = active;
            default: ;
        endcase
    end

    assign bus.halted = (state_q == S_HALT);
    assign bus.fault  = (state_q == S_FAULT);
    assign bus.state  = state_q;
endmodule
